morse_char_encoder: RTL and testbench

Upstream pattern source for the board's single user LED. It accepts ASCII characters over a valid/ready handshake and drives LED with correctly timed International Morse code, replacing the hard-coded SOS pattern word. A fixed unit timer derived from CLK sets all durations; the LED output goes straight to the board pin (CLK 16 MHz on TinyFPGA BX).

---
 rtl/morse_char_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_morse_char_encoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/morse_char_encoder.sv
// Morse LED pattern source: takes ASCII characters over valid/ready and plays them
// on a single LED with ITU Morse timing built from a fixed unit timer.

module morse_char_encoder_chk (
    input logic clk,
    input logic rst_n,
    input logic char_ready,
    input logic led,
    input logic busy
);
    // Readiness only exists while idle, and a lit LED always means a character is in flight
    a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(char_ready && busy));
    a_led_implies_busy: assert property (@(posedge clk) disable iff (!rst_n) led |-> busy);
endmodule

module morse_char_encoder #(
    parameter int unsigned UNIT_CYCLES = 2097152,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] CHAR_DATA,
    input  logic       CHAR_VALID,
    output logic       CHAR_READY,
    output logic       LED,
    output logic       BUSY
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MARK     = 3'd1,
        S_ELEM_GAP = 3'd2,
        S_CHAR_GAP = 3'd3,
        S_WORD_GAP = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 32'd1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       unit_q, unit_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       pat_q, pat_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [8:0]       code_s;
    logic             xfer_s;
    logic             tick_s;
    logic [2:0]       unit_len_s;
    logic             last_unit_s;

    // Result is {known, length, elements}; elements are right-aligned with the first at [length-1], 1 = dash
    function automatic logic [8:0] morse_lookup(input logic [7:0] ch);
        logic [7:0] up;
        logic [8:0] code;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            up = ch - 8'h20;
        end else begin
            up = ch;
        end
        case (up)
            8'h41:   code = {1'b1, 3'd2, 5'b00001};
            8'h42:   code = {1'b1, 3'd4, 5'b01000};
            8'h43:   code = {1'b1, 3'd4, 5'b01010};
            8'h44:   code = {1'b1, 3'd3, 5'b00100};
            8'h45:   code = {1'b1, 3'd1, 5'b00000};
            8'h46:   code = {1'b1, 3'd4, 5'b00010};
            8'h47:   code = {1'b1, 3'd3, 5'b00110};
            8'h48:   code = {1'b1, 3'd4, 5'b00000};
            8'h49:   code = {1'b1, 3'd2, 5'b00000};
            8'h4A:   code = {1'b1, 3'd4, 5'b00111};
            8'h4B:   code = {1'b1, 3'd3, 5'b00101};
            8'h4C:   code = {1'b1, 3'd4, 5'b00100};
            8'h4D:   code = {1'b1, 3'd2, 5'b00011};
            8'h4E:   code = {1'b1, 3'd2, 5'b00010};
            8'h4F:   code = {1'b1, 3'd3, 5'b00111};
            8'h50:   code = {1'b1, 3'd4, 5'b00110};
            8'h51:   code = {1'b1, 3'd4, 5'b01101};
            8'h52:   code = {1'b1, 3'd3, 5'b00010};
            8'h53:   code = {1'b1, 3'd3, 5'b00000};
            8'h54:   code = {1'b1, 3'd1, 5'b00001};
            8'h55:   code = {1'b1, 3'd3, 5'b00001};
            8'h56:   code = {1'b1, 3'd4, 5'b00001};
            8'h57:   code = {1'b1, 3'd3, 5'b00011};
            8'h58:   code = {1'b1, 3'd4, 5'b01001};
            8'h59:   code = {1'b1, 3'd4, 5'b01011};
            8'h5A:   code = {1'b1, 3'd4, 5'b01100};
            8'h30:   code = {1'b1, 3'd5, 5'b11111};
            8'h31:   code = {1'b1, 3'd5, 5'b01111};
            8'h32:   code = {1'b1, 3'd5, 5'b00111};
            8'h33:   code = {1'b1, 3'd5, 5'b00011};
            8'h34:   code = {1'b1, 3'd5, 5'b00001};
            8'h35:   code = {1'b1, 3'd5, 5'b00000};
            8'h36:   code = {1'b1, 3'd5, 5'b10000};
            8'h37:   code = {1'b1, 3'd5, 5'b11000};
            8'h38:   code = {1'b1, 3'd5, 5'b11100};
            8'h39:   code = {1'b1, 3'd5, 5'b11110};
            default: code = {1'b0, 3'd0, 5'b00000};
        endcase
        return code;
    endfunction

    // Next-state, timer and output computation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        code_s  = morse_lookup(CHAR_DATA);
        xfer_s  = CHAR_VALID && ready_q;
        tick_s  = (cnt_q == UNIT_LAST);

        case (state_q)
            S_MARK:     unit_len_s = pat_q[idx_q] ? 3'd3 : 3'd1;
            S_ELEM_GAP: unit_len_s = 3'd1;
            S_CHAR_GAP: unit_len_s = 3'd3;
            S_WORD_GAP: unit_len_s = 3'd4;
            default:    unit_len_s = 3'd1;
        endcase
        last_unit_s = tick_s && (unit_q == (unit_len_s - 3'd1));

        if (state_q != S_IDLE) begin
            cnt_d  = tick_s ? '0 : (cnt_q + CNT_W'(1));
            unit_d = tick_s ? (unit_q + 3'd1) : unit_q;
        end else begin
            cnt_d  = '0;
            unit_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (xfer_s && code_s[8]) begin
                    state_d = S_MARK;
                    pat_d   = code_s[4:0];
                    idx_d   = code_s[7:5] - 3'd1;
                end else if (xfer_s && (CHAR_DATA == 8'h20)) begin
                    state_d = S_WORD_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MARK: begin
                if (last_unit_s) begin
                    if (idx_q != 3'd0) begin
                        state_d = S_ELEM_GAP;
                        idx_d   = idx_q - 3'd1;
                    end else begin
                        state_d = S_CHAR_GAP;
                    end
                end else begin
                    state_d = S_MARK;
                end
            end
            S_ELEM_GAP: begin
                if (last_unit_s) begin
                    state_d = S_MARK;
                end else begin
                    state_d = S_ELEM_GAP;
                end
            end
            S_CHAR_GAP, S_WORD_GAP: begin
                if (last_unit_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state entry restarts both the cycle timer and the unit count
        if (state_d != state_q) begin
            cnt_d  = '0;
            unit_d = '0;
        end else begin
            cnt_d  = cnt_d;
            unit_d = unit_d;
        end

        led_d   = (state_d == S_MARK);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs, cleared by the synchronous reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            unit_q  <= 3'd0;
            idx_q   <= 3'd0;
            pat_q   <= 5'd0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            unit_q  <= unit_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign CHAR_READY = ready_q;
    assign LED        = led_q;
    assign BUSY       = busy_q;

    morse_char_encoder_chk u_chk (
        .clk        (CLK),
        .rst_n      (RST_N),
        .char_ready (ready_q),
        .led        (led_q),
        .busy       (busy_q)
    );
endmodule

// File: tb/tb_morse_char_encoder.sv
// Directed bench for morse_char_encoder with a 4-cycle Morse unit; expected LED
// patterns are written out by hand as unit strings.
module tb_morse_char_encoder;
    localparam int UNIT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       led;
    logic       busy;

    int checks = 0;
    int errors = 0;

    morse_char_encoder #(.UNIT_CYCLES(UNIT), .CNT_W(3)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .CHAR_DATA  (char_data),
        .CHAR_VALID (char_valid),
        .CHAR_READY (char_ready),
        .LED        (led),
        .BUSY       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (char_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (char_ready !== 1'b1) check({tag, " ready_timeout"}, char_ready, 1);
    endtask

    // Units string: '1' lit unit, '0' dark unit, 'i' the single idle handshake cycle between characters.
    // The first compared cycle is the one right after the first accept edge.
    task automatic stream(input string tag, input string chars, input string units);
        bit e_led[$];
        bit e_idle[$];
        int idx;
        int hs;
        logic xfer;
        for (int i = 0; i < units.len(); i++) begin
            if (units[i] == "i") begin
                e_led.push_back(1'b0);
                e_idle.push_back(1'b1);
            end else begin
                for (int k = 0; k < UNIT; k++) begin
                    e_led.push_back(units[i] == "1");
                    e_idle.push_back(1'b0);
                end
            end
        end
        wait_ready(tag);
        idx = 0;
        hs = 0;
        char_data = chars[0];
        char_valid = 1'b1;
        for (int c = 0; c < e_led.size(); c++) begin
            xfer = char_valid && char_ready;
            tick();
            if (xfer) begin
                hs++;
                idx++;
                if (idx < chars.len()) char_data = chars[idx];
                else char_valid = 1'b0;
            end
            check($sformatf("%s led c%0d", tag, c), led, e_led[c]);
            check($sformatf("%s busy c%0d", tag, c), busy, !e_idle[c]);
            check($sformatf("%s ready c%0d", tag, c), char_ready, e_idle[c]);
        end
        char_valid = 1'b0;
        check({tag, " handshakes"}, hs, chars.len());
        tick();
        check({tag, " ready_end"}, char_ready, 1);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " led_end"}, led, 0);
    endtask

    initial begin
        // Reset held for 3 edges with a character offered
        rst_n = 1'b0;
        char_valid = 1'b1;
        char_data = 8'h45;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst led", led, 0);
            check("rst ready", char_ready, 0);
            check("rst busy", busy, 0);
        end
        rst_n = 1'b1;
        tick();
        check("rel ready", char_ready, 1);
        check("rel led", led, 0);
        check("rel busy", busy, 0);
        char_valid = 1'b0;

        stream("E", "E", "1000");
        stream("SOS", "SOS", "10101000i11101110111000i10101000");
        stream("a", "a", "10111000");
        stream("A", "A", "10111000");
        stream("0", "0", "1110111011101110111000");
        // Space after T: ready returns 10 units plus the one idle handshake cycle after the T accept
        stream("T_space", "T ", "111000i0000");

        // Unsupported code is swallowed without leaving IDLE
        wait_ready("bang");
        char_data = 8'h21;
        char_valid = 1'b1;
        tick();
        check("bang ready", char_ready, 1);
        check("bang busy", busy, 0);
        check("bang led", led, 0);
        char_valid = 1'b0;
        tick();
        check("bang ready2", char_ready, 1);
        check("bang led2", led, 0);

        // Reset during the dash of T aborts the character
        wait_ready("abort");
        char_data = 8'h54;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        check("abort lit", led, 1);
        for (int i = 0; i < 2 * UNIT; i++) tick();
        check("abort still lit", led, 1);
        rst_n = 1'b0;
        tick();
        check("abort led", led, 0);
        check("abort ready", char_ready, 0);
        check("abort busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("abort rel ready", char_ready, 1);
        for (int i = 0; i < 3 * UNIT; i++) begin
            tick();
            check($sformatf("abort residue led c%0d", i), led, 0);
            check($sformatf("abort residue busy c%0d", i), busy, 0);
        end
        stream("E2", "E", "1000");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
